// File: rtl/vend_change.sv
// Coin-operated vending controller: banks nickels/dimes/quarters, vends once
// credit reaches PRICE, then pays any overpayment back one nickel per cycle.
//
// state   | meaning
// COLLECT | idle, accepting coins and cancel requests
// VEND    | one-cycle vend pulse; change (if any) follows
// CHANGE  | returning one nickel per cycle until chg_cnt is exhausted
module vend_change #(
  parameter int PRICE    = 6,
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                n,
  input  logic                d,
  input  logic                q,
  input  logic                cancel,
  output logic                y,
  output logic                chg_n,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

  state_t              state_q,    state_d;
  logic [CREDIT_W-1:0] credit_q,   credit_d;
  logic [CREDIT_W-1:0] chg_cnt_q,  chg_cnt_d;
  logic                coin_rej_q, coin_rej_d;

  logic [1:0]          coin_num;
  logic                any_coin;
  logic                valid_coin;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] overpay;

  assign coin_num   = {1'b0, n} + {1'b0, d} + {1'b0, q};
  assign any_coin   = n | d | q;
  assign valid_coin = (coin_num == 2'd1);

  always_comb begin
    coin_val = '0;
    if (n)      coin_val = (CREDIT_W+1)'(1);
    else if (d) coin_val = (CREDIT_W+1)'(2);
    else if (q) coin_val = (CREDIT_W+1)'(5);
  end

  // One extra bit keeps credit+coin from wrapping before the price compare.
  assign sum     = {1'b0, credit_q} + coin_val;
  assign overpay = sum[CREDIT_W-1:0] - PRICE_W[CREDIT_W-1:0];

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    chg_cnt_d  = chg_cnt_q;
    coin_rej_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (cancel) begin
          coin_rej_d = any_coin;
          if (credit_q != '0) begin
            chg_cnt_d = credit_q;
            credit_d  = '0;
            state_d   = CHANGE;
          end
        end else if (valid_coin) begin
          if (sum >= PRICE_W) begin
            state_d   = VEND;
            credit_d  = '0;
            chg_cnt_d = overpay;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
          end
        end else begin
          coin_rej_d = any_coin;
        end
      end
      VEND: begin
        coin_rej_d = any_coin;
        state_d    = (chg_cnt_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_rej_d = any_coin;
        chg_cnt_d  = chg_cnt_q - CREDIT_W'(1);
        if (chg_cnt_q == CREDIT_W'(1)) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      chg_cnt_q  <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      chg_cnt_q  <= chg_cnt_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  assign y        = (state_q == VEND);
  assign chg_n    = (state_q == CHANGE);
  assign busy     = (state_q != COLLECT);
  assign coin_rej = coin_rej_q;
  assign credit   = credit_q;

endmodule
